codificador_hamming_tx: RTL

- Transmit side of the Hamming SECDED link. It captures a 4-bit value from the switches when the load button is pressed (debounced).
- It encodes the value into an 8-bit extended Hamming(7,4) word, optionally injects 1 or 2 bit errors for lab demonstration, and presents the word on a valid/ready handshake.
- The downstream receiver/corrector consumes the word and produces the corrected nibble for the 7-segment decoder.

---
 rtl/codificador_hamming_tx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/codificador_hamming_tx.sv
// codificador_hamming_tx: transmit side of the Hamming SECDED lab link.
// Debounces the load button, captures the switch nibble plus the error
// injection settings on a press, encodes an extended Hamming(7,4) word with
// optional 1/2-bit error injection and offers it on a valid/ready handshake.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   dato_i       data nibble (dato_i[0] = d0)
//   btn_cargar_i raw, bouncing load button (active high)
//   err_modo_i   00 none, 01 single, 10 double, 11 none
//   err_pos_i    bit index of the injected error
//   ready_i      receiver accepts the word
//   valid_o      palabra_o holds a valid word
//   palabra_o    encoded word with error injection applied
//   ocupado_o    FSM not in IDLE
//   cuenta_o     number of completed handshakes (wraps)
module codificador_hamming_tx #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       dato_i,
    input  logic             btn_cargar_i,
    input  logic [1:0]       err_modo_i,
    input  logic [2:0]       err_pos_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [7:0]       palabra_o,
    output logic             ocupado_o,
    output logic [CNT_W-1:0] cuenta_o
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CODIFICA = 2'd1,
        ENVIA    = 2'd2
    } state_t;

    // Clean word: bit index equals Hamming position, bit 0 is overall parity.
    function automatic logic [7:0] codifica(input logic [3:0] d);
        logic [7:0] w;
        logic       p1;
        logic       p2;
        logic       p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        w  = {d[3], d[2], d[1], p4, d[0], p2, p1, 1'b0};
        w[0] = ^w[7:1];
        return w;
    endfunction

    // Error mask; the double-error partner bit wraps from 7 to 0.
    function automatic logic [7:0] mascara(input logic [1:0] modo, input logic [2:0] pos);
        logic [7:0] m;
        case (modo)
            2'b01:   m = 8'h01 << pos;
            2'b10:   m = (8'h01 << pos) | (8'h01 << 3'(pos + 3'd1));
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    logic             sinc1_q, sinc2_q;
    logic             deb_q, deb_d;
    logic             deb_prev_q;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             press_c;

    state_t           state_q, state_d;
    logic [3:0]       dato_cap_q, dato_cap_d;
    logic [1:0]       modo_cap_q, modo_cap_d;
    logic [2:0]       pos_cap_q, pos_cap_d;
    logic [7:0]       palabra_q, palabra_d;
    logic             valid_q, valid_d;
    logic             ocupado_q, ocupado_d;
    logic [CNT_W-1:0] cuenta_q, cuenta_d;

    // Debounce: a new level is accepted after DEBOUNCE_CYCLES consecutive
    // samples that disagree with the current level; any agreeing sample
    // restarts the count.
    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = '0;
        if (sinc2_q != deb_q) begin
            if (db_cnt_q == DB_MAX) begin
                deb_d    = sinc2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // The press event is seen one cycle after the debounced edge.
    assign press_c = deb_q & ~deb_prev_q;

    // Input synchronizer and debounce registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sinc1_q    <= 1'b0;
            sinc2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            db_cnt_q   <= '0;
        end else begin
            sinc1_q    <= btn_cargar_i;
            sinc2_q    <= sinc1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            db_cnt_q   <= db_cnt_d;
        end
    end

    // State register plus registered outputs and captured operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dato_cap_q <= 4'h0;
            modo_cap_q <= 2'b00;
            pos_cap_q  <= 3'd0;
            palabra_q  <= 8'h00;
            valid_q    <= 1'b0;
            ocupado_q  <= 1'b0;
            cuenta_q   <= '0;
        end else begin
            state_q    <= state_d;
            dato_cap_q <= dato_cap_d;
            modo_cap_q <= modo_cap_d;
            pos_cap_q  <= pos_cap_d;
            palabra_q  <= palabra_d;
            valid_q    <= valid_d;
            ocupado_q  <= ocupado_d;
            cuenta_q   <= cuenta_d;
        end
    end

    // Next-state logic; presses outside IDLE are simply dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (press_c) state_d = CODIFICA;
            CODIFICA: state_d = ENVIA;
            ENVIA:    if (valid_q && ready_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        dato_cap_d = dato_cap_q;
        modo_cap_d = modo_cap_q;
        pos_cap_d  = pos_cap_q;
        palabra_d  = palabra_q;
        valid_d    = valid_q;
        cuenta_d   = cuenta_q;
        ocupado_d  = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (press_c) begin
                    dato_cap_d = dato_i;
                    modo_cap_d = err_modo_i;
                    pos_cap_d  = err_pos_i;
                end
            end
            CODIFICA: begin
                palabra_d = codifica(dato_cap_q) ^ mascara(modo_cap_q, pos_cap_q);
                valid_d   = 1'b1;
            end
            ENVIA: begin
                if (valid_q && ready_i) begin
                    valid_d  = 1'b0;
                    cuenta_d = cuenta_q + CNT_W'(1);
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    assign valid_o   = valid_q;
    assign palabra_o = palabra_q;
    assign ocupado_o = ocupado_q;
    assign cuenta_o  = cuenta_q;

endmodule
